short_circuit_eval: RTL and testbench

Sequential, parametrised condition evaluator that checks up to TERMS comparison terms one per clock, in AND or OR mode. It stops at the first term that fixes the result (short-circuit), then registers a selected WIDTH-bit output value. It is the general form of the single compare-then-assign FSM step emitted for `if (a == b) x <= p; else x <= q;`. It sits between a control sequencer (start/done handshake) and the datapath registers it drives.

---
 rtl/short_circuit_eval.sv | 160 ++++++++++++++++
 tb/tb_short_circuit_eval.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/short_circuit_eval.sv
// rtl/short_circuit_eval.sv - sequential short-circuit AND/OR condition evaluator
module short_circuit_eval #(
  parameter int WIDTH = 32,
  parameter int TERMS = 4,
  parameter int CNTW  = $clog2(TERMS + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   mode,
  input  logic [TERMS*WIDTH-1:0] lhs,
  input  logic [TERMS*WIDTH-1:0] rhs,
  input  logic [TERMS*2-1:0]     cmp_op,
  input  logic [WIDTH-1:0]       val_true,
  input  logic [WIDTH-1:0]       val_false,
  output logic                   busy,
  output logic                   done,
  output logic                   result,
  output logic [WIDTH-1:0]       out1,
  output logic [CNTW-1:0]        terms_evaluated
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EVAL = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [CNTW-1:0]        idx_q, idx_d;
  logic                   mode_q, mode_d;
  logic [TERMS*WIDTH-1:0] lhs_q, lhs_d;
  logic [TERMS*WIDTH-1:0] rhs_q, rhs_d;
  logic [TERMS*2-1:0]     op_q, op_d;
  logic [WIDTH-1:0]       vt_q, vt_d;
  logic [WIDTH-1:0]       vf_q, vf_d;
  logic                   result_q, result_d;
  logic [WIDTH-1:0]       out1_q, out1_d;
  logic [CNTW-1:0]        terms_q, terms_d;

  logic [WIDTH-1:0]       cur_lhs;
  logic [WIDTH-1:0]       cur_rhs;
  logic [1:0]             cur_op;
  logic                   term_true;
  logic                   stop;
  logic                   stop_result;

  // Select the latched term at the current index and compare it (unsigned, full width)
  always_comb begin
    cur_lhs = '0;
    cur_rhs = '0;
    cur_op  = 2'b00;
    for (int i = 0; i < TERMS; i++) begin
      if (idx_q == CNTW'(i)) begin
        cur_lhs = lhs_q[i*WIDTH +: WIDTH];
        cur_rhs = rhs_q[i*WIDTH +: WIDTH];
        cur_op  = op_q[i*2 +: 2];
      end
    end
    case (cur_op)
      2'b00:   term_true = (cur_lhs == cur_rhs);
      2'b01:   term_true = (cur_lhs != cur_rhs);
      2'b10:   term_true = (cur_lhs <  cur_rhs);
      default: term_true = (cur_lhs >= cur_rhs);
    endcase
    // A deciding term fixes the result; otherwise the last term yields the chain's identity value
    if (!mode_q && !term_true) begin
      stop        = 1'b1;
      stop_result = 1'b0;
    end else if (mode_q && term_true) begin
      stop        = 1'b1;
      stop_result = 1'b1;
    end else begin
      stop        = (idx_q == CNTW'(TERMS - 1));
      stop_result = ~mode_q;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_EVAL;
      S_EVAL:  if (stop)  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Operand capture on accept, index advance and result registration on stop
  always_comb begin
    idx_d    = idx_q;
    mode_d   = mode_q;
    lhs_d    = lhs_q;
    rhs_d    = rhs_q;
    op_d     = op_q;
    vt_d     = vt_q;
    vf_d     = vf_q;
    result_d = result_q;
    out1_d   = out1_q;
    terms_d  = terms_q;
    if (state_q == S_IDLE && start) begin
      idx_d  = '0;
      mode_d = mode;
      lhs_d  = lhs;
      rhs_d  = rhs;
      op_d   = cmp_op;
      vt_d   = val_true;
      vf_d   = val_false;
    end else if (state_q == S_EVAL) begin
      if (stop) begin
        result_d = stop_result;
        out1_d   = stop_result ? vt_q : vf_q;
        terms_d  = idx_q + CNTW'(1);
      end else begin
        idx_d = idx_q + CNTW'(1);
      end
    end
  end

  // Output decode from registered state
  always_comb begin
    busy = (state_q == S_EVAL) || (state_q == S_DONE);
    done = (state_q == S_DONE);
  end

  assign result          = result_q;
  assign out1            = out1_q;
  assign terms_evaluated = terms_q;

  // State and datapath registers, asynchronously cleared
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      mode_q   <= 1'b0;
      lhs_q    <= '0;
      rhs_q    <= '0;
      op_q     <= '0;
      vt_q     <= '0;
      vf_q     <= '0;
      result_q <= 1'b0;
      out1_q   <= '0;
      terms_q  <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      mode_q   <= mode_d;
      lhs_q    <= lhs_d;
      rhs_q    <= rhs_d;
      op_q     <= op_d;
      vt_q     <= vt_d;
      vf_q     <= vf_d;
      result_q <= result_d;
      out1_q   <= out1_d;
      terms_q  <= terms_d;
    end
  end

endmodule

// File: tb/tb_short_circuit_eval.sv
// tb/tb_short_circuit_eval.sv - self-checking bench for short_circuit_eval
module tb_short_circuit_eval;
  localparam int WIDTH = 32;
  localparam int TERMS = 4;
  localparam int CNTW  = $clog2(TERMS + 1);

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   start;
  logic                   mode;
  logic [TERMS*WIDTH-1:0] lhs;
  logic [TERMS*WIDTH-1:0] rhs;
  logic [TERMS*2-1:0]     cmp_op;
  logic [WIDTH-1:0]       val_true;
  logic [WIDTH-1:0]       val_false;
  logic                   busy;
  logic                   done;
  logic                   result;
  logic [WIDTH-1:0]       out1;
  logic [CNTW-1:0]        terms_evaluated;

  logic [WIDTH-1:0] t_lhs [TERMS];
  logic [WIDTH-1:0] t_rhs [TERMS];
  logic [1:0]       t_op  [TERMS];

  int compared = 0;
  int mism     = 0;

  short_circuit_eval #(.WIDTH(WIDTH), .TERMS(TERMS)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .lhs(lhs), .rhs(rhs), .cmp_op(cmp_op),
    .val_true(val_true), .val_false(val_false),
    .busy(busy), .done(done), .result(result), .out1(out1),
    .terms_evaluated(terms_evaluated)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit term_val(input int i);
    case (t_op[i])
      2'd0:    return t_lhs[i] == t_rhs[i];
      2'd1:    return t_lhs[i] != t_rhs[i];
      2'd2:    return t_lhs[i] <  t_rhs[i];
      default: return t_lhs[i] >= t_rhs[i];
    endcase
  endfunction

  // AND is true unless some term is false; OR is false unless some term is true.
  // The count is the position of the first deciding term, or all terms if none decides.
  function automatic void model(input bit m, output bit r, output int k);
    int first = -1;
    for (int i = 0; i < TERMS; i++)
      if (first < 0 && term_val(i) == m) first = i;
    if (first >= 0) begin r = m;  k = first + 1; end
    else            begin r = !m; k = TERMS;     end
  endfunction

  task automatic set_term(input int i, input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] r, input logic [1:0] op);
    t_lhs[i] = l; t_rhs[i] = r; t_op[i] = op;
  endtask

  task automatic drive_terms();
    for (int i = 0; i < TERMS; i++) begin
      lhs[i*WIDTH +: WIDTH] = t_lhs[i];
      rhs[i*WIDTH +: WIDTH] = t_rhs[i];
      cmp_op[i*2 +: 2]      = t_op[i];
    end
  endtask

  // Called at a negedge with the DUT idle. Checks latency, outputs, busy and return to IDLE.
  task automatic run(input bit m, input bit pulse, input bit scramble,
                     input bit exp_r, input int exp_k, input string tag);
    logic [WIDTH-1:0] exp_out;
    int seen_at = 0;
    exp_out = exp_r ? val_true : val_false;
    mode = m;
    drive_terms();
    start = 1'b1;
    @(posedge clk); @(negedge clk);
    chk({tag, " busy_after_accept"}, busy, 1'b1);
    start = pulse;
    if (scramble) begin
      lhs       = ~lhs;
      rhs       = ~rhs;
      val_false = $urandom;
      val_true  = $urandom;
      mode      = ~m;
    end
    for (int c = 1; c <= TERMS + 2; c++) begin
      @(posedge clk); @(negedge clk);
      start = 1'b0;
      if (done) begin seen_at = c; break; end
      chk({tag, " busy_in_eval"}, busy, 1'b1);
    end
    chk({tag, " done_latency"}, seen_at, exp_k);
    chk({tag, " result"}, result, exp_r);
    chk({tag, " out1"}, out1, exp_out);
    chk({tag, " terms_evaluated"}, terms_evaluated, exp_k);
    @(posedge clk); @(negedge clk);
    chk({tag, " done_one_cycle"}, done, 1'b0);
    chk({tag, " busy_idle"}, busy, 1'b0);
    chk({tag, " result_hold"}, result, exp_r);
    chk({tag, " out1_hold"}, out1, exp_out);
  endtask

  initial begin
    bit mr;
    int mk;
    reset = 1'b0; start = 1'b0; mode = 1'b0;
    lhs = '0; rhs = '0; cmp_op = '0;
    val_true = 32'd25; val_false = 32'd15;
    for (int i = 0; i < TERMS; i++) set_term(i, 0, 0, 2'd0);
    #2;
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    chk("reset result", result, 1'b0);
    chk("reset out1", out1, 32'd0);
    chk("reset terms", terms_evaluated, 3'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b1;

    // AND short-circuit on term0
    set_term(0, 32'd291, 32'd4, 2'd0);
    set_term(1, 32'd1, 32'd1, 2'd0);
    set_term(2, 32'd1, 32'd1, 2'd0);
    set_term(3, 32'd1, 32'd1, 2'd0);
    run(1'b0, 1'b0, 1'b0, 1'b0, 1, "and_short");

    // AND full pass
    set_term(0, 32'd5, 32'd5, 2'd0);
    set_term(1, 32'd3, 32'd4, 2'd1);
    set_term(2, 32'd2, 32'd9, 2'd2);
    set_term(3, 32'd9, 32'd9, 2'd3);
    run(1'b0, 1'b0, 1'b0, 1'b1, 4, "and_full");

    // Same run with a start pulse during EVAL and inputs changed after accept
    run(1'b0, 1'b1, 1'b1, 1'b1, 4, "and_full_pulse");
    val_true = 32'd25; val_false = 32'd15;

    // OR stops on term2
    set_term(0, 32'd1, 32'd2, 2'd0);
    set_term(1, 32'd3, 32'd3, 2'd1);
    set_term(2, 32'd2, 32'd9, 2'd2);
    set_term(3, 32'd1, 32'd2, 2'd0);
    run(1'b1, 1'b0, 1'b0, 1'b1, 3, "or_early");

    // OR all false
    set_term(2, 32'd5, 32'd3, 2'd2);
    run(1'b1, 1'b0, 1'b0, 1'b0, 4, "or_none");

    // Unsigned compare: all-ones is not less than 1; operands changed one cycle after accept
    set_term(0, 32'hFFFF_FFFF, 32'd1, 2'd2);
    run(1'b0, 1'b1, 1'b1, 1'b0, 1, "unsigned_lt");
    val_true = 32'd25; val_false = 32'd15;

    // Establish non-zero outputs, then assert reset mid-cycle
    set_term(0, 32'd5, 32'd5, 2'd0);
    set_term(1, 32'd3, 32'd4, 2'd1);
    set_term(2, 32'd2, 32'd9, 2'd2);
    set_term(3, 32'd9, 32'd9, 2'd3);
    run(1'b0, 1'b0, 1'b0, 1'b1, 4, "pre_reset");
    @(posedge clk); #2 reset = 1'b0; #1;
    chk("async_reset busy", busy, 1'b0);
    chk("async_reset done", done, 1'b0);
    chk("async_reset result", result, 1'b0);
    chk("async_reset out1", out1, 32'd0);
    chk("async_reset terms", terms_evaluated, 3'd0);
    @(negedge clk); reset = 1'b1;

    // Reset at E2 of a 4-term AND run: run abandoned, no done pulse
    mode = 1'b0; drive_terms(); start = 1'b1;
    @(posedge clk); @(negedge clk); start = 1'b0;
    @(posedge clk); @(posedge clk); #1 reset = 1'b0; #1;
    chk("mid_eval_reset busy", busy, 1'b0);
    begin
      int done_seen = 0;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        if (done) done_seen++;
      end
      chk("mid_eval_reset no_done", done_seen, 0);
    end
    reset = 1'b1;
    run(1'b0, 1'b0, 1'b0, 1'b1, 4, "after_reset");

    // Randomized runs against the reference model
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < TERMS; i++) begin
        if ($urandom_range(0, 3) == 0)
          set_term(i, $urandom, $urandom, 2'($urandom_range(0, 3)));
        else
          set_term(i, $urandom_range(0, 3), $urandom_range(0, 3), 2'($urandom_range(0, 3)));
      end
      val_true  = $urandom;
      val_false = $urandom;
      mode      = 1'($urandom_range(0, 1));
      model(mode, mr, mk);
      run(mode, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), mr, mk, "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end
endmodule
